// File: rtl/rep_cmps_pkg.sv
// Shared types for the CMPS / REPE CMPS / REPNE CMPS execute sequencer.
package rep_cmps_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        RD_SRC,
        RD_DST,
        UPD,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WORD  = 2'd1,
        SZ_DWORD = 2'd2,
        SZ_RSVD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        REP_NONE = 2'd0,
        REP_E    = 2'd1,
        REP_NE   = 2'd2,
        REP_RSVD = 2'd3
    } rep_e;

    // Bit positions on the ALU1 flag bus {OF,SF,ZF,AF,PF,CF}
    localparam int FLAGS_W = 6;
    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_AF = 2;
    localparam int FLAG_ZF = 3;
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 5;

endpackage

// File: rtl/rep_cmps_seq_if.sv
// Control, memory-read and writeback bundle between the execute stage and the CMPS sequencer.
interface rep_cmps_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              flush;
    logic              start_valid;
    logic              start_ready;
    logic [1:0]        rep_type;
    logic [1:0]        op_size;
    logic              df;
    logic [ADDR_W-1:0] esi_in;
    logic [ADDR_W-1:0] edi_in;
    logic [CNT_W-1:0]  ecx_in;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [1:0]        mem_rd_size;
    logic              mem_rd_ack;
    logic              lat_en;
    logic [5:0]        cmps_flags;
    logic              done_valid;
    logic [ADDR_W-1:0] esi_out;
    logic [ADDR_W-1:0] edi_out;
    logic [CNT_W-1:0]  ecx_out;
    logic [5:0]        flags_out;
    logic [5:0]        ld_flags;

    modport slave (
        input  flush, start_valid, rep_type, op_size, df, esi_in, edi_in, ecx_in,
               mem_rd_ack, cmps_flags,
        output start_ready, mem_rd_req, mem_rd_addr, mem_rd_size, lat_en,
               done_valid, esi_out, edi_out, ecx_out, flags_out, ld_flags
    );

    modport master (
        output flush, start_valid, rep_type, op_size, df, esi_in, edi_in, ecx_in,
               mem_rd_ack, cmps_flags,
        input  start_ready, mem_rd_req, mem_rd_addr, mem_rd_size, lat_en,
               done_valid, esi_out, edi_out, ecx_out, flags_out, ld_flags
    );
endinterface

// File: rtl/rep_cmps_seq_stride.sv
// Pointer step for one string element: +/-1, 2 or 4 depending on size and direction flag.
module cmps_stride
    import rep_cmps_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                     op_size_i,
    input  logic [1:0]               op_size,
    input  logic                     df,
    output logic signed [ADDR_W-1:0] stride
);
    logic [ADDR_W-1:0] mag;

    always_comb begin
        mag = ADDR_W'(4);
        case (op_size)
            SZ_BYTE: mag = ADDR_W'(1);
            SZ_WORD: mag = ADDR_W'(2);
            default: mag = ADDR_W'(4);
        endcase
        stride = df ? $signed(-mag) : $signed(mag);
    end

    logic unused_ok;
    assign unused_ok = op_size_i;
endmodule

// File: rtl/rep_cmps_seq.sv
// CMPS sequencer: source read, destination read, pointer/count update, REP termination,
// one writeback pulse per instruction.
module rep_cmps_seq
    import rep_cmps_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input logic       clk,
    input logic       rst,
    rep_cmps_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] esi_q, esi_d, edi_q, edi_d;
    logic [CNT_W-1:0]  ecx_q, ecx_d;
    logic [5:0]        flags_q, flags_d;
    logic [1:0]        rep_q, rep_d, size_q, size_d;
    logic              df_q, df_d, ran_q, ran_d;

    logic signed [ADDR_W-1:0] stride;
    logic              is_rep;
    logic [CNT_W-1:0]  ecx_dec;

    cmps_stride #(.ADDR_W(ADDR_W)) u_stride (
        .op_size_i (1'b0),
        .op_size   (size_q),
        .df        (df_q),
        .stride    (stride)
    );

    assign is_rep  = (rep_q == REP_E) || (rep_q == REP_NE);
    assign ecx_dec = ecx_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        esi_d   = esi_q;
        edi_d   = edi_q;
        ecx_d   = ecx_q;
        flags_d = flags_q;
        rep_d   = rep_q;
        size_d  = size_q;
        df_d    = df_q;
        ran_d   = ran_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start_valid) begin
                    esi_d   = bus.esi_in;
                    edi_d   = bus.edi_in;
                    ecx_d   = bus.ecx_in;
                    rep_d   = bus.rep_type;
                    size_d  = bus.op_size;
                    df_d    = bus.df;
                    ran_d   = 1'b0;
                    state_d = CHK;
                end
                CHK:    state_d = (is_rep && ecx_q == '0) ? DONE : RD_SRC;
                RD_SRC: if (bus.mem_rd_ack) state_d = RD_DST;
                RD_DST: if (bus.mem_rd_ack) begin
                    flags_d = bus.cmps_flags;
                    ran_d   = 1'b1;
                    state_d = UPD;
                end
                UPD: begin
                    esi_d   = esi_q + $unsigned(stride);
                    edi_d   = edi_q + $unsigned(stride);
                    state_d = RD_SRC;
                    if (is_rep) ecx_d = ecx_dec;
                    // ZF comes from the compare just captured in RD_DST
                    if (!is_rep || ecx_dec == '0 ||
                        (rep_q == REP_E  && !flags_q[FLAG_ZF]) ||
                        (rep_q == REP_NE &&  flags_q[FLAG_ZF]))
                        state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            esi_q   <= '0;
            edi_q   <= '0;
            ecx_q   <= '0;
            flags_q <= '0;
            rep_q   <= '0;
            size_q  <= '0;
            df_q    <= 1'b0;
            ran_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            esi_q   <= esi_d;
            edi_q   <= edi_d;
            ecx_q   <= ecx_d;
            flags_q <= flags_d;
            rep_q   <= rep_d;
            size_q  <= size_d;
            df_q    <= df_d;
            ran_q   <= ran_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.mem_rd_req  = (state_q == RD_SRC) || (state_q == RD_DST);
    assign bus.mem_rd_addr = (state_q == RD_SRC) ? esi_q :
                             (state_q == RD_DST) ? edi_q : '0;
    assign bus.mem_rd_size = size_q;
    assign bus.lat_en      = (state_q == RD_SRC) && bus.mem_rd_ack && !bus.flush && !rst;
    assign bus.done_valid  = (state_q == DONE);
    assign bus.esi_out     = esi_q;
    assign bus.edi_out     = edi_q;
    assign bus.ecx_out     = ecx_q;
    assign bus.flags_out   = flags_q;
    assign bus.ld_flags    = (state_q == DONE && ran_q) ? 6'h3F : 6'h00;
endmodule
